sqrt_arbiter: RTL and testbench

Round-robin controller that shares one iterative `sqrt` core (N-bit signed in, N/2-bit root out, `done` on completion) among NUM_REQ requesters in the attention datapath, such as per-head scaling and normalisation units. It accepts operands over valid/ready, sequences the core's start (reset) and done protocol, and returns each root tagged with the requester ID over a single valid/ready response channel. Negative operands are rejected without using the core.

---
 rtl/sqrt_arbiter_pkg.sv | 19 +
 rtl/sqrt_arbiter_if.sv | 32 +++
 rtl/sqrt_arbiter_rr_arbiter.sv | 30 +++
 rtl/sqrt_arbiter.sv | 120 ++++++++++++
 tb/tb_sqrt_arbiter.sv | 405 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/sqrt_arbiter_pkg.sv
// Shared types and constants for the sqrt_arbiter slice: FSM state encoding,
// requester-ID width helper and the small-operand bypass threshold.
package sqrt_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    // Operands strictly below this value have root 0 or 1 and can skip the core.
    localparam int BYPASS_THRESHOLD = 4;

    function automatic int calc_id_w(input int num_req);
        return (num_req <= 2) ? 1 : $clog2(num_req);
    endfunction

endpackage

// File: rtl/sqrt_arbiter_if.sv
// Request/response bundle between NUM_REQ requesters and the sqrt arbiter.
// master = requester side, slave = arbiter side.
interface sqrt_arbiter_if #(
    parameter int N       = 32,
    parameter int NUM_REQ = 4
);
    import sqrt_arb_pkg::*;

    localparam int ID_W = calc_id_w(NUM_REQ);

    // Valid/ready: a transfer happens on a rising clk edge where both valid and
    // ready are high; once valid is raised, the payload holds until that edge.
    logic [NUM_REQ-1:0]   req_valid;
    logic [NUM_REQ-1:0]   req_ready;
    logic [NUM_REQ*N-1:0] req_operand;
    logic                 rsp_valid;
    logic                 rsp_ready;
    logic [ID_W-1:0]      rsp_id;
    logic [N/2-1:0]       rsp_root;
    logic                 rsp_err;

    modport master (
        output req_valid, req_operand, rsp_ready,
        input  req_ready, rsp_valid, rsp_id, rsp_root, rsp_err
    );

    modport slave (
        input  req_valid, req_operand, rsp_ready,
        output req_ready, rsp_valid, rsp_id, rsp_root, rsp_err
    );

endinterface

// File: rtl/sqrt_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first asserted request at or after ptr,
// wrapping, as a one-hot grant plus its encoded index.
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [ID_W-1:0]    idx,
    output logic               any
);

    always_comb begin
        int j;
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        j     = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            j = (int'(ptr) + k) % NUM_REQ;
            if (!any && req[j]) begin
                grant[j] = 1'b1;
                idx      = ID_W'(j);
                any      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/sqrt_arbiter.sv
// Round-robin front end sharing one iterative sqrt core among NUM_REQ requesters.
// Optional macro SQRT_ARB_SMALL_BYPASS_EN: operands 0..3 are answered without the core.
module sqrt_arbiter
    import sqrt_arb_pkg::*;
#(
    parameter int N       = 32,
    parameter int NUM_REQ = 4
) (
    input  logic             clk,
    input  logic             rst,
    sqrt_arbiter_if.slave    bus,
    output logic             core_start,
    output logic [N-1:0]     core_num_in,
    input  logic [N/2-1:0]   core_sq_root,
    input  logic             core_done,
    output logic             busy,
    output state_t           dbg_state
);

    localparam int ID_W = calc_id_w(NUM_REQ);
    localparam int RW   = N / 2;

    state_t              state;
    logic [ID_W-1:0]     ptr;
    logic [ID_W-1:0]     id_q;
    logic [RW-1:0]       root_q;
    logic                err_q;
    logic                valid_q;
    logic                start_q;
    logic [N-1:0]        op_q;

    logic [NUM_REQ-1:0]  grant;
    logic [ID_W-1:0]     gnt_idx;
    logic                gnt_any;
    logic [N-1:0]        win_op;

    rr_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) u_rr_arbiter (
        .req   (bus.req_valid),
        .ptr   (ptr),
        .grant (grant),
        .idx   (gnt_idx),
        .any   (gnt_any)
    );

    assign win_op = bus.req_operand[gnt_idx*N +: N];

    // Grants exist only in IDLE; gated by rst so req_ready reads 0 during reset.
    assign bus.req_ready = (state == IDLE && !rst) ? grant : '0;
    assign bus.rsp_valid = valid_q;
    assign bus.rsp_id    = id_q;
    assign bus.rsp_root  = root_q;
    assign bus.rsp_err   = err_q;

    // The core is held in reset alongside the arbiter.
    assign core_start  = rst | start_q;
    assign core_num_in = op_q;
    assign busy        = (state != IDLE);
    assign dbg_state   = state;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            ptr     <= '0;
            id_q    <= '0;
            root_q  <= '0;
            err_q   <= 1'b0;
            valid_q <= 1'b0;
            start_q <= 1'b0;
            op_q    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (gnt_any) begin
                        id_q <= gnt_idx;
                        if (win_op[N-1]) begin
                            err_q   <= 1'b1;
                            root_q  <= '0;
                            valid_q <= 1'b1;
                            state   <= RESP;
                        end
`ifdef SQRT_ARB_SMALL_BYPASS_EN
                        else if (win_op < N'(BYPASS_THRESHOLD)) begin
                            err_q   <= 1'b0;
                            root_q  <= RW'(win_op != '0);
                            valid_q <= 1'b1;
                            state   <= RESP;
                        end
`endif
                        else begin
                            err_q   <= 1'b0;
                            op_q    <= win_op;
                            start_q <= 1'b1;
                            state   <= START;
                        end
                    end
                end
                START: begin
                    start_q <= 1'b0;
                    state   <= WAIT;
                end
                WAIT: begin
                    if (core_done) begin
                        root_q  <= core_sq_root;
                        valid_q <= 1'b1;
                        state   <= RESP;
                    end
                end
                RESP: begin
                    if (bus.rsp_ready) begin
                        valid_q <= 1'b0;
                        ptr     <= (id_q == ID_W'(NUM_REQ - 1)) ? '0 : id_q + ID_W'(1);
                        state   <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sqrt_arbiter.sv
// Directed self-checking bench for sqrt_arbiter with a behavioural iterative sqrt core
// (4 WAIT cycles per operation) attached to the core_* ports.
module tb_sqrt_arbiter;
  import sqrt_arb_pkg::*;

  localparam int N       = 32;
  localparam int NUM_REQ = 4;
  localparam int ID_W    = 2;
  localparam int RW      = 16;
  localparam int CORE_LAT = 6;  // grant -> rsp_valid through the core model

  // clock/reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  sqrt_arbiter_if #(.N(N), .NUM_REQ(NUM_REQ)) bus ();

  logic          core_start;
  logic [N-1:0]  core_num_in;
  logic [RW-1:0] core_sq_root;
  logic          core_done;
  logic          busy;
  state_t        dbg_state;

  sqrt_arbiter #(.N(N), .NUM_REQ(NUM_REQ)) dut (
    .clk          (clk),
    .rst          (rst),
    .bus          (bus.slave),
    .core_start   (core_start),
    .core_num_in  (core_num_in),
    .core_sq_root (core_sq_root),
    .core_done    (core_done),
    .busy         (busy),
    .dbg_state    (dbg_state)
  );

  int checks = 0;
  int failures = 0;
  int start_cnt = 0;
  logic [ID_W+RW-1:0] exp_q[$];

  function automatic logic [RW-1:0] isqrt(input logic [N-1:0] x);
    logic [RW-1:0] r;
    logic [RW-1:0] t;
    longint unsigned tt;
    r = '0;
    for (int b = RW - 1; b >= 0; b--) begin
      t = r | (RW'(1) << b);
      tt = longint'(t);
      if (tt * tt <= longint'(x)) r = t;
    end
    return r;
  endfunction

  // behavioural core: reset by core_start, done asserted after a fixed delay and held
  int core_cnt = 0;
  logic [N-1:0] core_num;
  always @(posedge clk) begin
    if (core_start) begin
      core_cnt     <= 3;
      core_done    <= 1'b0;
      core_num     <= core_num_in;
      core_sq_root <= '0;
    end else if (core_cnt == 1) begin
      core_cnt     <= 0;
      core_done    <= 1'b1;
      core_sq_root <= isqrt(core_num);
    end else if (core_cnt > 1) begin
      core_cnt <= core_cnt - 1;
    end
  end

  always @(posedge clk) if (core_start && !rst) start_cnt <= start_cnt + 1;

  // driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    bus.req_valid = '0;
    bus.rsp_ready = 1'b0;
    step();
    rst = 1'b0;
    step();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.req_valid = '1;
    bus.req_operand = {32'd25, 32'd16, 32'd9, 32'd4};
    bus.rsp_ready = 1'b0;
    step();
    step();
    checks++;
    if ({bus.req_ready, bus.rsp_valid, bus.rsp_err, busy, core_start} !== 8'b0000_0001) begin
      failures++;
      $display("FAIL reset_ctrl actual=%b required=%b", {bus.req_ready, bus.rsp_valid, bus.rsp_err, busy, core_start}, 8'b0000_0001);
    end
    checks++;
    if ({bus.rsp_id, bus.rsp_root, core_num_in} !== '0) begin
      failures++;
      $display("FAIL reset_data actual=%h required=0", {bus.rsp_id, bus.rsp_root, core_num_in});
    end
    checks++;
    if (dbg_state !== IDLE) begin
      failures++;
      $display("FAIL reset_state actual=%0d required=%0d", dbg_state, IDLE);
    end
    bus.req_valid = '0;
    rst = 1'b0;
    step();
  endtask

  task automatic test_single();
    int s0;
    int n;
    s0 = start_cnt;
    bus.req_operand[0 +: N] = 32'd144;
    bus.req_valid = 4'b0001;
    #1;
    checks++;
    if (bus.req_ready !== 4'b0001) begin
      failures++;
      $display("FAIL single_grant actual=%b required=0001", bus.req_ready);
    end
    step();
    bus.req_valid = '0;
    checks++;
    if ({core_start, core_num_in} !== {1'b1, 32'd144}) begin
      failures++;
      $display("FAIL single_start actual=%b/%0d required=1/144", core_start, core_num_in);
    end
    n = 1;
    while (!bus.rsp_valid && n < 50) begin
      step();
      n++;
    end
    checks++;
    if (n !== CORE_LAT) begin
      failures++;
      $display("FAIL single_latency actual=%0d required=%0d", n, CORE_LAT);
    end
    checks++;
    if ({bus.rsp_valid, bus.rsp_id, bus.rsp_root, bus.rsp_err} !== {1'b1, 2'd0, 16'd12, 1'b0}) begin
      failures++;
      $display("FAIL single_rsp actual=v%b id%0d root%0d err%b required=v1 id0 root12 err0", bus.rsp_valid, bus.rsp_id, bus.rsp_root, bus.rsp_err);
    end
    checks++;
    if (start_cnt - s0 !== 1) begin
      failures++;
      $display("FAIL single_pulses actual=%0d required=1", start_cnt - s0);
    end
    bus.rsp_ready = 1'b1;
    step();
    bus.rsp_ready = 1'b0;
    checks++;
    if ({bus.rsp_valid, busy} !== 2'b00) begin
      failures++;
      $display("FAIL single_release actual=%b required=00", {bus.rsp_valid, busy});
    end
  endtask

  task automatic test_all_four();
    logic [NUM_REQ-1:0] g;
    logic [ID_W+RW-1:0] e;
    int got;
    int cyc;
    apply_reset();
    bus.req_operand = {32'd25, 32'd16, 32'd9, 32'd4};
    exp_q.push_back({2'd0, 16'd2});
    exp_q.push_back({2'd1, 16'd3});
    exp_q.push_back({2'd2, 16'd4});
    exp_q.push_back({2'd3, 16'd5});
    bus.rsp_ready = 1'b1;
    bus.req_valid = 4'b1111;
    got = 0;
    cyc = 0;
    while (got < 4 && cyc < 200) begin
      #1;
      g = bus.req_ready;
      if (bus.rsp_valid) begin
        e = exp_q.pop_front();
        checks++;
        if ({bus.rsp_id, bus.rsp_root, bus.rsp_err} !== {e, 1'b0}) begin
          failures++;
          $display("FAIL all_four_rsp%0d actual=id%0d root%0d err%b required=id%0d root%0d err0", got, bus.rsp_id, bus.rsp_root, bus.rsp_err, e[RW +: ID_W], e[RW-1:0]);
        end
        got++;
      end
      step();
      cyc++;
      bus.req_valid = bus.req_valid & ~g;
    end
    bus.rsp_ready = 1'b0;
    checks++;
    if (got !== 4) begin
      failures++;
      $display("FAIL all_four_count actual=%0d required=4", got);
    end
    exp_q.delete();
  endtask

  task automatic test_alternate();
    logic [ID_W+RW-1:0] e;
    int got;
    int cyc;
    bus.req_operand[0 +: N] = 32'd65535;
    bus.req_operand[2*N +: N] = 32'd1024;
    exp_q.push_back({2'd0, 16'd255});
    exp_q.push_back({2'd2, 16'd32});
    exp_q.push_back({2'd0, 16'd255});
    exp_q.push_back({2'd2, 16'd32});
    bus.rsp_ready = 1'b1;
    bus.req_valid = 4'b0101;
    got = 0;
    cyc = 0;
    while (got < 4 && cyc < 200) begin
      #1;
      if (bus.rsp_valid) begin
        e = exp_q.pop_front();
        checks++;
        if ({bus.rsp_id, bus.rsp_root, bus.rsp_err} !== {e, 1'b0}) begin
          failures++;
          $display("FAIL alternate_rsp%0d actual=id%0d root%0d err%b required=id%0d root%0d err0", got, bus.rsp_id, bus.rsp_root, bus.rsp_err, e[RW +: ID_W], e[RW-1:0]);
        end
        got++;
      end
      step();
      cyc++;
    end
    bus.req_valid = '0;
    bus.rsp_ready = 1'b0;
    checks++;
    if (got !== 4) begin
      failures++;
      $display("FAIL alternate_count actual=%0d required=4", got);
    end
    exp_q.delete();
  endtask

  task automatic test_negative();
    int s0;
    s0 = start_cnt;
    bus.req_operand[N +: N] = -32'sd5;
    bus.req_valid = 4'b0010;
    #1;
    checks++;
    if (bus.req_ready !== 4'b0010) begin
      failures++;
      $display("FAIL neg_grant actual=%b required=0010", bus.req_ready);
    end
    step();
    bus.req_valid = '0;
    checks++;
    if ({bus.rsp_valid, bus.rsp_id, bus.rsp_root, bus.rsp_err, core_start} !== {1'b1, 2'd1, 16'd0, 1'b1, 1'b0}) begin
      failures++;
      $display("FAIL neg_rsp actual=v%b id%0d root%0d err%b start%b required=v1 id1 root0 err1 start0", bus.rsp_valid, bus.rsp_id, bus.rsp_root, bus.rsp_err, core_start);
    end
    bus.rsp_ready = 1'b1;
    step();
    bus.rsp_ready = 1'b0;
    checks++;
    if (start_cnt !== s0) begin
      failures++;
      $display("FAIL neg_pulses actual=%0d required=%0d", start_cnt, s0);
    end
  endtask

  task automatic test_backpressure_reset();
    int n;
    bus.req_operand[N +: N] = 32'd49;
    bus.req_operand[2*N +: N] = 32'd100;
    bus.req_valid = 4'b0010;
    step();
    bus.req_valid = 4'b0100;
    n = 0;
    while (!bus.rsp_valid && n < 50) begin
      step();
      n++;
    end
    for (int i = 0; i < 10; i++) begin
      #1;
      checks++;
      if ({bus.rsp_valid, bus.rsp_id, bus.rsp_root, bus.rsp_err, bus.req_ready} !== {1'b1, 2'd1, 16'd7, 1'b0, 4'b0000}) begin
        failures++;
        $display("FAIL hold_cycle%0d actual=v%b id%0d root%0d err%b rdy%b required=v1 id1 root7 err0 rdy0000", i, bus.rsp_valid, bus.rsp_id, bus.rsp_root, bus.rsp_err, bus.req_ready);
      end
      step();
    end
    bus.rsp_ready = 1'b1;
    step();
    bus.rsp_ready = 1'b0;
    checks++;
    if (bus.req_ready !== 4'b0100) begin
      failures++;
      $display("FAIL pending_grant actual=%b required=0100", bus.req_ready);
    end
    step();
    bus.req_valid = '0;
    step();
    step();
    checks++;
    if ({dbg_state, busy} !== {WAIT, 1'b1}) begin
      failures++;
      $display("FAIL pre_reset_state actual=%0d/%b required=%0d/1", dbg_state, busy, WAIT);
    end
    rst = 1'b1;
    bus.req_valid = 4'b1111;
    #1;
    checks++;
    if ({bus.req_ready, bus.rsp_valid, bus.rsp_err, busy, core_start, dbg_state} !== {4'b0000, 1'b0, 1'b0, 1'b0, 1'b1, IDLE}) begin
      failures++;
      $display("FAIL mid_reset actual=rdy%b v%b err%b busy%b start%b st%0d required=rdy0000 v0 err0 busy0 start1 st0", bus.req_ready, bus.rsp_valid, bus.rsp_err, busy, core_start, dbg_state);
    end
    checks++;
    if ({bus.rsp_id, bus.rsp_root, core_num_in} !== '0) begin
      failures++;
      $display("FAIL mid_reset_data actual=%h required=0", {bus.rsp_id, bus.rsp_root, core_num_in});
    end
    step();
    rst = 1'b0;
    #1;
    checks++;
    if (bus.req_ready !== 4'b0001) begin
      failures++;
      $display("FAIL ptr_after_reset actual=%b required=0001", bus.req_ready);
    end
    bus.req_valid = '0;
    for (int i = 0; i < 8; i++) step();
    checks++;
    if ({bus.rsp_valid, busy} !== 2'b00) begin
      failures++;
      $display("FAIL dropped_rsp actual=%b required=00", {bus.rsp_valid, busy});
    end
  endtask

  task automatic test_small_operands();
    logic [N-1:0]  ops   [4];
    logic [RW-1:0] roots [4];
    int s0;
    int n;
    int exp_n;
    int exp_p;
    ops   = '{32'd0, 32'd1, 32'd3, 32'd4};
    roots = '{16'd0, 16'd1, 16'd1, 16'd2};
    for (int k = 0; k < 4; k++) begin
`ifdef SQRT_ARB_SMALL_BYPASS_EN
      exp_n = (ops[k] < 32'd4) ? 1 : CORE_LAT;
      exp_p = (ops[k] < 32'd4) ? 0 : 1;
`else
      exp_n = CORE_LAT;
      exp_p = 1;
`endif
      s0 = start_cnt;
      bus.req_operand[0 +: N] = ops[k];
      bus.req_valid = 4'b0001;
      step();
      bus.req_valid = '0;
      n = 1;
      while (!bus.rsp_valid && n < 50) begin
        step();
        n++;
      end
      checks++;
      if ({bus.rsp_id, bus.rsp_root, bus.rsp_err} !== {2'd0, roots[k], 1'b0}) begin
        failures++;
        $display("FAIL small_op%0d_rsp actual=id%0d root%0d err%b required=id0 root%0d err0", ops[k], bus.rsp_id, bus.rsp_root, bus.rsp_err, roots[k]);
      end
      checks++;
      if (n !== exp_n || start_cnt - s0 !== exp_p) begin
        failures++;
        $display("FAIL small_op%0d_path actual=lat%0d pulses%0d required=lat%0d pulses%0d", ops[k], n, start_cnt - s0, exp_n, exp_p);
      end
      bus.rsp_ready = 1'b1;
      step();
      bus.rsp_ready = 1'b0;
    end
  endtask

  initial begin
    bus.req_valid   = '0;
    bus.req_operand = '0;
    bus.rsp_ready   = 1'b0;
    test_reset();
    test_single();
    test_all_four();
    test_alternate();
    test_negative();
    test_backpressure_reset();
    test_small_operands();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
